// File: rtl/sram_port_initiator.sv
// sram_port_initiator
//   Request-side controller for a single-port RW0 SRAM macro. Accepts
//   read/write requests on a valid/ready port, drives the SRAM RW port and
//   collects the one-cycle-latency read data into a 3-entry in-order
//   response FIFO. Read acceptance is credit-limited so the FIFO can never
//   overflow.
//
//   Optional feature macro: SRAM_PORT_INIT_EN
//     defined   -> after reset the whole array (DEPTH words) is zero-filled
//                  before init_done rises and traffic is accepted.
//     undefined -> no fill logic; the block comes out of reset ready.
//
// Ports
//   clock, reset_n           clock (also the SRAM clock), async active-low reset
//   req_valid/req_ready      request handshake
//   req_write                1 = write, 0 = read
//   req_addr/mask/wdata      word address, byte enables (writes only), data
//   rsp_valid/rsp_ready      response handshake, read data in request order
//   rsp_rdata                response data (FIFO head)
//   init_done                array ready for traffic
//   mem_en/mem_wmode         SRAM RW0_en / RW0_wmode
//   mem_addr/wmask/wdata     SRAM RW0_addr / RW0_wmask / RW0_wdata
//   mem_rdata                SRAM RW0_rdata (valid the cycle after a read)
module sram_port_initiator #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4096
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W/8-1:0] req_mask,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                init_done,
  output logic                mem_en,
  output logic                mem_wmode,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned FIFO_DEPTH = 3;

  if (DEPTH == 0 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $error("sram_port_initiator: DEPTH must be in 1..2**ADDR_W");
  end

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            w_state;
  logic [ADDR_W-1:0] w_fill_addr;

`ifdef SRAM_PORT_INIT_EN
  localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_fill_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_INIT;
      r_fill_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT) r_fill_cnt <= r_fill_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_INIT && r_fill_cnt == FILL_LAST) w_state_nxt = ST_RUN;
  end

  assign w_state     = r_state;
  assign w_fill_addr = r_fill_cnt;
  assign init_done   = (r_state == ST_RUN);
`else
  assign w_state     = ST_RUN;
  assign w_fill_addr = '0;
  assign init_done   = 1'b1;
`endif

  // Response FIFO and read-credit bookkeeping
  logic [DATA_W-1:0] r_buf [FIFO_DEPTH];
  logic [1:0]        r_wr_ptr;
  logic [1:0]        r_rd_ptr;
  logic [1:0]        r_count;
  logic              r_inflight;
  logic [2:0]        w_credit;
  logic              w_req_ready;
  logic              w_rd_fire;
  logic              w_pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit counts the read whose data arrives this cycle, so a push that
  // coincides with a full FIFO can never happen.
  assign w_credit    = {1'b0, r_count} + {2'b00, r_inflight};
  assign w_req_ready = reset_n && (w_state == ST_RUN) &&
                       (req_write || (w_credit < 3'(FIFO_DEPTH)));
  assign w_rd_fire   = req_valid && w_req_ready && !req_write;
  assign w_pop       = rsp_valid && rsp_ready;

  assign req_ready = w_req_ready;
  assign rsp_valid = (r_count != 2'd0);
  assign rsp_rdata = r_buf[r_rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_inflight <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_buf[i] <= '0;
    end else begin
      r_inflight <= w_rd_fire;
      if (r_inflight) begin
        r_buf[r_wr_ptr] <= mem_rdata;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({r_inflight, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // SRAM port: fill writes while initialising, else pass accepted requests.
  // Gated by reset_n so the port is idle while reset is held.
  always_comb begin
    mem_en    = 1'b0;
    mem_wmode = 1'b0;
    mem_addr  = '0;
    mem_wmask = '0;
    mem_wdata = '0;
    if (reset_n && w_state == ST_INIT) begin
      mem_en    = 1'b1;
      mem_wmode = 1'b1;
      mem_addr  = w_fill_addr;
      mem_wmask = '1;
      mem_wdata = '0;
    end else if (req_valid && w_req_ready) begin
      mem_en    = 1'b1;
      mem_wmode = req_write;
      mem_addr  = req_addr;
      mem_wmask = req_mask;
      mem_wdata = req_wdata;
    end
  end

endmodule

// File: tb/tb_sram_port_initiator.sv
module tb_sram_port_initiator;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4096;

`ifdef SRAM_PORT_INIT_EN
  localparam logic FILL_ON = 1'b1;
`else
  localparam logic FILL_ON = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              req_valid, req_ready, req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [3:0]        req_mask;
  logic [31:0]       req_wdata;
  logic              rsp_valid, rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              init_done;
  logic              mem_en, mem_wmode;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wmask;
  logic [31:0]       mem_wdata, mem_rdata;

  always #5 clock = ~clock;

  sram_port_initiator #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_mask(req_mask), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .mem_en(mem_en), .mem_wmode(mem_wmode), .mem_addr(mem_addr),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // SRAM macro model: 1-cycle read latency, byte-masked writes, non-zero power-up contents
  logic [31:0] sram [DEPTH];
  logic [31:0] sram_q;
  assign mem_rdata = sram_q;

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) sram[i] = 32'hDEAD0000 | i;
    sram_q = '0;
    forever begin
      @(posedge clock);
      if (mem_en) begin
        if (mem_wmode) begin
          for (int b = 0; b < 4; b++)
            if (mem_wmask[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end else begin
          sram_q <= sram[mem_addr];
        end
      end
    end
  end

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_q [$];
  int unsigned run_len = 0;
  int unsigned max_run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Response monitor / scoreboard
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clock);
      if (reset_n && rsp_valid && rsp_ready) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rsp_unexpected: response 0x%08h delivered, none required", rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_data", rsp_rdata, e);
        end
      end else begin
        run_len = 0;
      end
    end
  end

  // Drive one request starting at posedge+1; returns at posedge+1 after acceptance
  task automatic issue(input logic wr, input logic [ADDR_W-1:0] addr, input logic [3:0] mask,
                       input logic [31:0] wdata, input logic [31:0] exp, output int unsigned stalls);
    stalls    = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_mask  = mask;
    req_wdata = wdata;
    @(negedge clock);
    while (!req_ready && stalls < 20) begin
      stalls++;
      @(negedge clock);
    end
    if (!req_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL req_accept: req_ready=0 after %0d cycles, required 1", stalls);
    end else if (!wr) begin
      exp_q.push_back(exp);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        mask;
    logic [31:0]       wdata;
    logic [31:0]       exp;
  } vec_t;

  initial begin
    vec_t        tbl [13];
    int unsigned st, tot, acc, cnt, stale, fill_err;

    tbl[0]  = '{1'b1, 12'h010, 4'hF, 32'hAABBCCDD, 32'h0};
    tbl[1]  = '{1'b1, 12'h010, 4'h5, 32'h11223344, 32'h0};
    tbl[2]  = '{1'b0, 12'h010, 4'h0, 32'h0,        32'hAA22CC44};
    tbl[3]  = '{1'b1, 12'h020, 4'hF, 32'h00000005, 32'h0};
    tbl[4]  = '{1'b0, 12'h020, 4'h0, 32'h0,        32'h00000005};
    tbl[5]  = '{1'b1, 12'h020, 4'hF, 32'h00000009, 32'h0};
    tbl[6]  = '{1'b0, 12'h020, 4'h0, 32'h0,        32'h00000009};
    tbl[7]  = '{1'b1, 12'h030, 4'hF, 32'h12345678, 32'h0};
    tbl[8]  = '{1'b1, 12'h030, 4'h8, 32'hFF000000, 32'h0};
    tbl[9]  = '{1'b1, 12'h030, 4'h0, 32'hFFFFFFFF, 32'h0};
    tbl[10] = '{1'b0, 12'h030, 4'h0, 32'h0,        32'hFF345678};
    tbl[11] = '{1'b1, 12'h030, 4'hA, 32'hA1B2C3D4, 32'h0};
    tbl[12] = '{1'b0, 12'h030, 4'h0, 32'h0,        32'hA134C378};

    req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_mask = '0; req_wdata = '0; rsp_ready = 1'b1;
    step(3);

    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_wmode", mem_wmode, 0);
    chk("rst_init_done", init_done, FILL_ON ? 0 : 1);

`ifdef SRAM_PORT_INIT_EN
    reset_n  = 1'b1;
    fill_err = 0;
    for (int unsigned k = 0; k <= 100; k++) begin
      @(negedge clock);
      if (!(mem_en && mem_addr == ADDR_W'(k))) fill_err++;
    end
    chk("fill_first_addrs", fill_err, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_fill_mem_en", mem_en, 0);
    chk("rst_mid_fill_init_done", init_done, 0);
    chk("rst_mid_fill_req_ready", req_ready, 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    fill_err = 0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      @(negedge clock);
      if (!(mem_en && mem_wmode && mem_wmask == 4'hF && mem_wdata == 32'h0 &&
            mem_addr == ADDR_W'(k) && !init_done && !req_ready)) fill_err++;
    end
    chk("fill_sequence", fill_err, 0);
    @(negedge clock);
    chk("fill_init_done", init_done, 1);
    chk("fill_req_ready", req_ready, 1);
    chk("fill_mem_en_idle", mem_en, 0);
    @(posedge clock);
    #1;
    issue(1'b0, 12'hFFF, 4'h0, 32'h0, 32'h0, st);
    idle();
    step(4);
`else
    reset_n = 1'b1;
    @(negedge clock);
    chk("nofill_init_done", init_done, 1);
    chk("nofill_req_ready_first", req_ready, 1);
    @(posedge clock);
    #1;
`endif

    // Table: applied back-to-back, reads scored through the queue
    tot = 0;
    foreach (tbl[i]) begin
      issue(tbl[i].wr, tbl[i].addr, tbl[i].mask, tbl[i].wdata, tbl[i].exp, st);
      tot += st;
    end
    idle();
    chk("tbl_stalls", tot, 0);
    step(4);

    // Read latency: accepted in T, rsp_valid in T+2
    issue(1'b0, 12'h010, 4'h0, 32'h0, 32'hAA22CC44, st);
    idle();
    @(negedge clock);
    chk("lat_t1_rsp_valid", rsp_valid, 0);
    @(negedge clock);
    chk("lat_t2_rsp_valid", rsp_valid, 1);
    chk("lat_t2_rsp_rdata", rsp_rdata, 32'hAA22CC44);
    @(posedge clock);
    #1;
    step(2);

    // Back-to-back reads
    for (int unsigned a = 0; a < 8; a++) issue(1'b1, ADDR_W'(a), 4'hF, a * 3, 32'h0, st);
    idle();
    step(3);
    max_run = 0;
    tot = 0;
    for (int unsigned a = 0; a < 8; a++) begin
      issue(1'b0, ADDR_W'(a), 4'h0, 32'h0, a * 3, st);
      tot += st;
    end
    idle();
    chk("b2b_stalls", tot, 0);
    step(4);
    chk("b2b_rsp_run", max_run, 8);

    // Backpressure: reads stop after 3, writes still pass
    rsp_ready = 1'b0;
    acc = 0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = '0; req_mask = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      cnt = req_ready ? 1 : 0;
      if (req_ready) begin
        exp_q.push_back(32'(req_addr) * 3);
        acc++;
      end
      @(posedge clock);
      #1;
      if (cnt != 0) req_addr = req_addr + 1'b1;
    end
    chk("bp_reads_accepted", acc, 3);
    @(negedge clock);
    chk("bp_read_ready_low", req_ready, 0);
    chk("bp_rsp_valid", rsp_valid, 1);
    req_write = 1'b1; req_addr = 12'h100; req_mask = 4'hF; req_wdata = 32'h0BADF00D;
    #1;
    chk("bp_write_ready", req_ready, 1);
    @(posedge clock);
    #1;
    idle();
    rsp_ready = 1'b1;
    step(6);
    chk("bp_drained", exp_q.size(), 0);
    issue(1'b0, 12'h100, 4'h0, 32'h0, 32'h0BADF00D, st);
    idle();
    step(4);

    // Reset with two responses queued
    rsp_ready = 1'b0;
    issue(1'b0, 12'h001, 4'h0, 32'h0, 32'h3, st);
    issue(1'b0, 12'h002, 4'h0, 32'h0, 32'h6, st);
    idle();
    step(2);
    chk("pre_rst_rsp_valid", rsp_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_q_rsp_valid", rsp_valid, 0);
    chk("rst_q_rsp_rdata", rsp_rdata, 0);
    chk("rst_q_req_ready", req_ready, 0);
    chk("rst_q_mem_en", mem_en, 0);
    chk("rst_q_mem_wmode", mem_wmode, 0);
    chk("rst_q_init_done", init_done, FILL_ON ? 0 : 1);
    exp_q.delete();
    rsp_ready = 1'b1;
    @(posedge clock);
    #1 reset_n = 1'b1;
    stale = 0;
    cnt = 0;
    while ((!init_done || cnt < 10) && cnt < DEPTH + 20) begin
      @(negedge clock);
      if (rsp_valid) stale++;
      @(posedge clock);
      #1;
      cnt++;
    end
    chk("post_rst_no_stale", stale, 0);
    chk("post_rst_init_done", init_done, 1);

    issue(1'b0, 12'h020, 4'h0, 32'h0, FILL_ON ? 32'h0 : 32'h9, st);
    idle();
    step(5);
    chk("final_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
